iobuf_ctrl: RTL

- FPGA-side controller that drives one Bus Pirate IO channel: 74LVC1T45 direction (bufdir), 74LVC1G07 open-drain (bufod) and the tristate FPGA data pin (bufio).
- Sequences direction changes with guard cycles so the FPGA never drives bufio while the 1T45 is driving towards the FPGA.
- Returns a synchronised, glitch-filtered input bit to the protocol engines.
- Sits between each protocol engine pin and the iobufphy buffer model / real buffers.

---
 rtl/iobuf_ctrl_pkg.sv | 26 ++
 rtl/iobuf_ctrl_if.sv | 30 +++
 rtl/iobuf_infilter.sv | 53 +++++
 rtl/iobuf_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/iobuf_ctrl_pkg.sv
// Shared encodings and defaults for the IO buffer controller.
// Also holds the mode decode used by the controller.
package iobuf_ctrl_pkg;

   localparam logic [1:0] MODE_HIZ = 2'b00;
   localparam logic [1:0] MODE_PP  = 2'b01;
   localparam logic [1:0] MODE_OD  = 2'b10;
   localparam logic [1:0] MODE_RSV = 2'b11;

   localparam int GUARD_CYCLES_DEF = 2;
   localparam int FILTER_LEN_DEF   = 3;

   typedef enum logic [2:0] {
      S_IN       = 3'd0,
      S_OD       = 3'd1,
      S_TURN_OUT = 3'd2,
      S_PP       = 3'd3,
      S_TURN_IN  = 3'd4
   } state_t;

   // The reserved encoding behaves exactly like HiZ input.
   function automatic logic [1:0] eff_mode(input logic [1:0] m);
      return (m == MODE_RSV) ? MODE_HIZ : m;
   endfunction

endpackage

// File: rtl/iobuf_ctrl_if.sv
// Engine-side signal bundle between a protocol engine and its IO buffer controller.
// The engine is the master; the controller is the slave.
interface iobuf_ctrl_if;

   logic [1:0] mode;
   logic       dout;
   logic       din;
   logic       din_change;
   logic       busy;
   logic [1:0] cur_mode;

   modport master (
      output mode,
      output dout,
      input  din,
      input  din_change,
      input  busy,
      input  cur_mode
   );

   modport slave (
      input  mode,
      input  dout,
      output din,
      output din_change,
      output busy,
      output cur_mode
   );

endinterface

// File: rtl/iobuf_infilter.sv
// Two-flop synchroniser followed by a run-length glitch filter.
// din follows the synchronised pin once it has disagreed with din for FILTER_LEN clocks.
module iobuf_infilter
   import iobuf_ctrl_pkg::*;
#(
   parameter int FILTER_LEN = FILTER_LEN_DEF
) (
   input  logic clock,
   input  logic reset_n,
   input  logic pin,
   output logic din,
   output logic din_change
);

   localparam logic [3:0] RUN_MAX = 4'(FILTER_LEN);

   logic       sync1;
   logic       sync2;
   logic [3:0] run_cnt;
   logic [3:0] run_next;

   // Saturating increment; the run counter never wraps.
   always_comb begin
      run_next = run_cnt;
      if (run_cnt != RUN_MAX) begin
         run_next = run_cnt + 4'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         run_cnt    <= 4'd0;
         din        <= 1'b0;
         din_change <= 1'b0;
      end else begin
         sync1      <= pin;
         sync2      <= sync1;
         din_change <= 1'b0;
         if (sync2 == din) begin
            run_cnt <= 4'd0;
         end else if (run_next == RUN_MAX) begin
            din        <= sync2;
            din_change <= 1'b1;
            run_cnt    <= 4'd0;
         end else begin
            run_cnt <= run_next;
         end
      end
   end

endmodule

// File: rtl/iobuf_ctrl.sv
// Direction/open-drain sequencer for one IO channel with turnaround guard cycles.
// The FPGA only drives bufio after the 1T45 has been pointed away from the FPGA.
//
// state      | meaning
// S_IN       | HiZ input, 1T45 drives towards FPGA
// S_OD       | open-drain output via 1G07, bufod = registered dout
// S_TURN_OUT | bufdir flipped to output, waiting before enabling FPGA drive
// S_PP       | push-pull output, FPGA drives bufio with dout
// S_TURN_IN  | FPGA drive released, waiting before flipping bufdir back
module iobuf_ctrl
   import iobuf_ctrl_pkg::*;
#(
   parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
   parameter int FILTER_LEN   = FILTER_LEN_DEF
) (
   input  logic        clock,
   input  logic        reset_n,
   iobuf_ctrl_if.slave eng,
   output logic        bufdir,
   output logic        bufod,
   inout  wire         bufio
);

   localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] guard_cnt;
   logic [3:0] guard_next;
   logic [1:0] mode_eff;
   logic       oe;
   logic       dout_q;
   logic       busy_q;
   logic [1:0] cur_mode_q;
   logic       bufdir_next;
   logic       oe_next;
   logic       bufod_next;
   logic       busy_next;
   logic [1:0] cur_mode_next;

   always_comb begin
      state_next = state;
      guard_next = guard_cnt;
      mode_eff   = eff_mode(eng.mode);
      case (state)
         S_IN: begin
            if (mode_eff == MODE_OD) begin
               state_next = S_OD;
            end else if (mode_eff == MODE_PP) begin
               state_next = S_TURN_OUT;
               guard_next = GUARD_LOAD;
            end
         end
         S_OD: begin
            if (mode_eff == MODE_HIZ) begin
               state_next = S_IN;
            end else if (mode_eff == MODE_PP) begin
               state_next = S_TURN_OUT;
               guard_next = GUARD_LOAD;
            end
         end
         // Turnarounds ignore mode until done; the mode seen afterwards decides.
         S_TURN_OUT: begin
            if (guard_cnt == 4'd0) begin
               state_next = S_PP;
            end else begin
               guard_next = guard_cnt - 4'd1;
            end
         end
         S_PP: begin
            if (mode_eff != MODE_PP) begin
               state_next = S_TURN_IN;
               guard_next = GUARD_LOAD;
            end
         end
         S_TURN_IN: begin
            if (guard_cnt == 4'd0) begin
               state_next = S_IN;
            end else begin
               guard_next = guard_cnt - 4'd1;
            end
         end
         default: begin
            state_next = S_IN;
         end
      endcase
   end

   // Pin controls are decoded from the next state so they register with it.
   always_comb begin
      bufdir_next   = 1'b0;
      oe_next       = 1'b0;
      bufod_next    = 1'b1;
      busy_next     = 1'b0;
      cur_mode_next = cur_mode_q;
      case (state_next)
         S_IN: begin
            cur_mode_next = MODE_HIZ;
         end
         S_OD: begin
            bufod_next    = eng.dout;
            cur_mode_next = MODE_OD;
         end
         S_TURN_OUT: begin
            bufdir_next = 1'b1;
            busy_next   = 1'b1;
         end
         S_PP: begin
            bufdir_next   = 1'b1;
            oe_next       = 1'b1;
            cur_mode_next = MODE_PP;
         end
         S_TURN_IN: begin
            bufdir_next = 1'b1;
            busy_next   = 1'b1;
         end
         default: begin
            cur_mode_next = MODE_HIZ;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= S_IN;
         guard_cnt  <= 4'd0;
         bufdir     <= 1'b0;
         oe         <= 1'b0;
         bufod      <= 1'b1;
         busy_q     <= 1'b0;
         cur_mode_q <= MODE_HIZ;
         dout_q     <= 1'b0;
      end else begin
         state      <= state_next;
         guard_cnt  <= guard_next;
         bufdir     <= bufdir_next;
         oe         <= oe_next;
         bufod      <= bufod_next;
         busy_q     <= busy_next;
         cur_mode_q <= cur_mode_next;
         dout_q     <= eng.dout;
      end
   end

   assign bufio        = oe ? dout_q : 1'bz;
   assign eng.busy     = busy_q;
   assign eng.cur_mode = cur_mode_q;

   iobuf_infilter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_infilter (
      .clock      (clock),
      .reset_n    (reset_n),
      .pin        (bufio),
      .din        (eng.din),
      .din_change (eng.din_change)
   );

   a_oe_needs_dir: assert property (@(posedge clock) disable iff (!reset_n) oe |-> bufdir);
   a_od_only_in_od: assert property (@(posedge clock) disable iff (!reset_n) !bufod |-> (state == S_OD));

endmodule
